// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue between fetch and decode.
//
// Captures {pc, instruction} pairs from instruction memory and presents the
// oldest entry to decode through a show-ahead valid/ready handshake. hold_o
// is a registered almost-full indication so fetch can stop advancing its PC.
// flush_i (taken branch) discards every queued entry and wins over a write
// or read in the same cycle.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN
//   When defined, a write into an empty queue is forwarded combinationally
//   to the read side. If decode takes it in the same cycle, it is never stored.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   flush_i     taken-branch flush
//   wr_valid_i  write request
//   wr_pc_i     PC of the written instruction
//   wr_instr_i  instruction word
//   wr_ready_o  queue can accept a write this cycle
//   rd_valid_o  head entry valid
//   rd_ready_i  decode consumes head entry
//   rd_pc_o     PC of head entry (0 when empty)
//   rd_instr_o  instruction of head entry (0 when empty)
//   count_o     number of occupied entries
//   hold_o      almost-full, registered
module fetch_queue #(
  parameter int DEPTH       = 4,
  parameter int INSTR_W     = 16,
  parameter int HOLD_MARGIN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       wr_valid_i,
  input  logic [7:0]                 wr_pc_i,
  input  logic [INSTR_W-1:0]         wr_instr_i,
  output logic                       wr_ready_o,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [7:0]                 rd_pc_o,
  output logic [INSTR_W-1:0]         rd_instr_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       hold_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [7:0]         pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          hold_q, hold_d;

  logic head_valid;
  logic byp;
  logic push;
  logic pop;

  always_comb begin
    head_valid = (count_q != '0);
    wr_ready_o = (count_q < DEPTH_C);

`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (count_q == '0) & ~flush_i & wr_valid_i;
`else
    byp = 1'b0;
`endif

    rd_valid_o = head_valid | byp;
    // Data is zeroed when empty so stale (unreset) storage never shows.
    if (head_valid) begin
      rd_pc_o    = pc_mem[rd_ptr_q];
      rd_instr_o = instr_mem[rd_ptr_q];
    end else if (byp) begin
      rd_pc_o    = wr_pc_i;
      rd_instr_o = wr_instr_i;
    end else begin
      rd_pc_o    = '0;
      rd_instr_o = '0;
    end

    // A bypassed entry consumed in the same cycle never enters storage.
    push = wr_valid_i & wr_ready_o & ~flush_i & ~(byp & rd_ready_i);
    pop  = head_valid & rd_ready_i & ~flush_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush_i) begin
      // Pointers are made equal rather than zeroed; only the count matters.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    hold_d = ((DEPTH - int'(count_d)) <= HOLD_MARGIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= wr_pc_i;
      instr_mem[wr_ptr_q] <= wr_instr_i;
    end
  end

  assign count_o = count_q;
  assign hold_o  = hold_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        wr_valid_i;
  logic [7:0]  wr_pc_i;
  logic [15:0] wr_instr_i;
  logic        wr_ready_o;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic [7:0]  rd_pc_o;
  logic [15:0] rd_instr_o;
  logic [2:0]  count_o;
  logic        hold_o;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(4), .INSTR_W(16), .HOLD_MARGIN(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .wr_valid_i (wr_valid_i),
    .wr_pc_i    (wr_pc_i),
    .wr_instr_i (wr_instr_i),
    .wr_ready_o (wr_ready_o),
    .rd_valid_o (rd_valid_o),
    .rd_ready_i (rd_ready_i),
    .rd_pc_o    (rd_pc_o),
    .rd_instr_o (rd_instr_o),
    .count_o    (count_o),
    .hold_o     (hold_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        wv;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        rr;
    logic        e_rv;
    logic [7:0]  e_pc;
    logic [15:0] e_instr;
    logic [2:0]  e_cnt;
    logic        e_hold;
    logic        e_wrdy;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush_i    = 1'b0;
    wr_valid_i = 1'b0;
    wr_pc_i    = 8'h00;
    wr_instr_i = 16'h0000;
    rd_ready_i = 1'b0;
  endtask

  task automatic step(input logic fl, input logic wv, input logic [7:0] pc, input logic rr);
    flush_i    = fl;
    wr_valid_i = wv;
    wr_pc_i    = pc;
    wr_instr_i = {8'hC0, pc};
    rd_ready_i = rr;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    int exp_rd;
    int wr_idx;
    int cyc;

    idle_inputs();
    rst_n = 1'b0;

    //         fl wv pc     instr     rr | rv epc    einstr    cnt hold wrdy
    vecs[0]  = '{0, 1, 8'h10, 16'hA5A5, 0,  1, 8'h10, 16'hA5A5, 3'd1, 0, 1};
    vecs[1]  = '{0, 0, 8'h00, 16'h0000, 1,  0, 8'h00, 16'h0000, 3'd0, 0, 1};
    vecs[2]  = '{0, 1, 8'h00, 16'hC000, 0,  1, 8'h00, 16'hC000, 3'd1, 0, 1};
    vecs[3]  = '{0, 1, 8'h01, 16'hC001, 0,  1, 8'h00, 16'hC000, 3'd2, 0, 1};
    vecs[4]  = '{0, 1, 8'h02, 16'hC002, 0,  1, 8'h00, 16'hC000, 3'd3, 1, 1};
    vecs[5]  = '{0, 1, 8'h03, 16'hC003, 0,  1, 8'h00, 16'hC000, 3'd4, 1, 0};
    vecs[6]  = '{0, 1, 8'h04, 16'hC004, 0,  1, 8'h00, 16'hC000, 3'd4, 1, 0};
    vecs[7]  = '{0, 1, 8'h05, 16'hC005, 1,  1, 8'h01, 16'hC001, 3'd3, 1, 1};
    vecs[8]  = '{0, 0, 8'h00, 16'h0000, 1,  1, 8'h02, 16'hC002, 3'd2, 0, 1};
    vecs[9]  = '{0, 0, 8'h00, 16'h0000, 1,  1, 8'h03, 16'hC003, 3'd1, 0, 1};
    vecs[10] = '{0, 0, 8'h00, 16'h0000, 1,  0, 8'h00, 16'h0000, 3'd0, 0, 1};
    vecs[11] = '{0, 1, 8'h30, 16'hC030, 0,  1, 8'h30, 16'hC030, 3'd1, 0, 1};
    vecs[12] = '{0, 1, 8'h31, 16'hC031, 0,  1, 8'h30, 16'hC030, 3'd2, 0, 1};
    vecs[13] = '{0, 1, 8'h32, 16'hC032, 0,  1, 8'h30, 16'hC030, 3'd3, 1, 1};
    vecs[14] = '{1, 1, 8'h40, 16'hC040, 0,  0, 8'h00, 16'h0000, 3'd0, 0, 1};
    vecs[15] = '{1, 0, 8'h00, 16'h0000, 0,  0, 8'h00, 16'h0000, 3'd0, 0, 1};
    vecs[16] = '{0, 1, 8'h41, 16'hC041, 0,  1, 8'h41, 16'hC041, 3'd1, 0, 1};
    vecs[17] = '{0, 1, 8'h42, 16'hC042, 1,  1, 8'h42, 16'hC042, 3'd1, 0, 1};
    vecs[18] = '{1, 1, 8'h43, 16'hC043, 1,  0, 8'h00, 16'h0000, 3'd0, 0, 1};
    vecs[19] = '{0, 0, 8'h00, 16'h0000, 1,  0, 8'h00, 16'h0000, 3'd0, 0, 1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rd_valid", 0, 32'(rd_valid_o), 32'd0);
    check("rst_wr_ready", 0, 32'(wr_ready_o), 32'd1);
    check("rst_hold",     0, 32'(hold_o),     32'd0);
    check("rst_count",    0, 32'(count_o),    32'd0);
    check("rst_rd_pc",    0, 32'(rd_pc_o),    32'd0);
    check("rst_rd_instr", 0, 32'(rd_instr_o), 32'd0);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 20; i++) begin
      flush_i    = vecs[i].flush;
      wr_valid_i = vecs[i].wv;
      wr_pc_i    = vecs[i].pc;
      wr_instr_i = vecs[i].instr;
      rd_ready_i = vecs[i].rr;
      @(posedge clk);
      #1 idle_inputs();
      @(negedge clk);
      check("rd_valid", i, 32'(rd_valid_o), 32'(vecs[i].e_rv));
      check("rd_pc",    i, 32'(rd_pc_o),    32'(vecs[i].e_pc));
      check("rd_instr", i, 32'(rd_instr_o), 32'(vecs[i].e_instr));
      check("count",    i, 32'(count_o),    32'(vecs[i].e_cnt));
      check("hold",     i, 32'(hold_o),     32'(vecs[i].e_hold));
      check("wr_ready", i, 32'(wr_ready_o), 32'(vecs[i].e_wrdy));
    end

    // Pointer wrap: pc 0x20..0x29 through the queue with random read stalls
    exp_rd = 0;
    wr_idx = 0;
    cyc    = 0;
    while (exp_rd < 10 && cyc < 300) begin
      wr_valid_i = (wr_idx < 10);
      wr_pc_i    = 8'h20 + 8'(wr_idx);
      wr_instr_i = {8'hC0, wr_pc_i};
      rd_ready_i = 1'($urandom_range(0, 1));
      #1;
      if (rd_valid_o && rd_ready_i) begin
        check("wrap_pc", exp_rd, 32'(rd_pc_o), 32'h20 + 32'(exp_rd));
        check("wrap_instr", exp_rd, 32'(rd_instr_o), {16'h0, 8'hC0, 8'h20 + 8'(exp_rd)});
        exp_rd++;
      end
      if (wr_valid_i && wr_ready_o) wr_idx++;
      @(posedge clk);
      #1 idle_inputs();
      @(negedge clk);
      cyc++;
    end
    check("wrap_reads_done", 0, 32'(exp_rd), 32'd10);
    check("wrap_writes_done", 0, 32'(wr_idx), 32'd10);
    check("wrap_empty_count", 0, 32'(count_o), 32'd0);
    check("wrap_empty_valid", 0, 32'(rd_valid_o), 32'd0);

    // Asynchronous reset mid-operation, no clock edge during the pulse
    step(1'b0, 1'b1, 8'h60, 1'b0);
    step(1'b0, 1'b1, 8'h61, 1'b0);
    check("pre_rst_count", 0, 32'(count_o), 32'd2);
    #1 rst_n = 1'b0;
    #2;
    check("async_rst_valid", 0, 32'(rd_valid_o), 32'd0);
    check("async_rst_count", 0, 32'(count_o), 32'd0);
    check("async_rst_pc",    0, 32'(rd_pc_o),   32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_count", 0, 32'(count_o), 32'd0);
    step(1'b0, 1'b1, 8'h62, 1'b0);
    check("post_rst_first_pc", 0, 32'(rd_pc_o), 32'h62);
    check("post_rst_first_cnt", 0, 32'(count_o), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("post_rst_drain", 0, 32'(count_o), 32'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
    wr_valid_i = 1'b1;
    wr_pc_i    = 8'h50;
    wr_instr_i = 16'hC050;
    rd_ready_i = 1'b1;
    #1;
    check("byp_valid", 0, 32'(rd_valid_o), 32'd1);
    check("byp_pc",    0, 32'(rd_pc_o),    32'h50);
    check("byp_instr", 0, 32'(rd_instr_o), 32'hC050);
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check("byp_count", 0, 32'(count_o), 32'd0);
    check("byp_after_valid", 0, 32'(rd_valid_o), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue between the fetch stage's PC output and the decode stage.
- Captures each {pc, instruction} pair returned by instruction memory into a circular buffer.
- Presents entries to decode with a valid/ready handshake.
- Raises an almost-full hold so fetch can stop advancing; on a taken branch, flushes all stale entries.

Parameters:
- DEPTH, 4, number of entries; power of 2, minimum 2
- INSTR_W, 16, instruction word width in bits
- HOLD_MARGIN, 1, hold_o asserts when free entries <= HOLD_MARGIN; range 0..DEPTH-1

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  taken-branch flush; discards all queued entries
- wr_valid_i  in  1  write request; {wr_pc_i, wr_instr_i} is valid
- wr_pc_i  in  8  PC of the instruction being written
- wr_instr_i  in  INSTR_W  instruction word from instruction memory
- wr_ready_o  out  1  queue can accept a write this cycle
- rd_valid_o  out  1  head entry is valid
- rd_ready_i  in  1  decode consumes the head entry this cycle
- rd_pc_o  out  8  PC of the head entry
- rd_instr_o  out  INSTR_W  instruction word of the head entry
- count_o  out  $clog2(DEPTH)+1  number of occupied entries
- hold_o  out  1  almost-full; fetch must hold its PC

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - rd_valid_o=0, wr_ready_o=1, hold_o=0, count_o=0.
  - rd_pc_o=0, rd_instr_o=0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all entries immediately.
  - First write is accepted on the first rising edge after rst_n deasserts.
- Handshake events:
  - push = wr_valid_i & wr_ready_o.
  - pop = rd_valid_o & rd_ready_i.
  - Each transfers on the rising edge.
- Flow control:
  - wr_ready_o = (count < DEPTH), combinational from registered count.
  - Full: a write is refused even if a pop occurs in the same cycle (no pass-through when full).
  - rd_valid_o = (count != 0).
  - rd_pc_o / rd_instr_o are driven from the entry at rd_ptr (show-ahead).
  - Outputs hold stable while rd_valid_o=1 and rd_ready_i=0.
- Write latency: an entry pushed into an empty queue appears on rd_valid_o in the next cycle.
- Pointers:
  - Width $clog2(DEPTH); wrap naturally from DEPTH-1 to 0.
  - count is tracked separately, saturating at 0..DEPTH by construction.
- Simultaneous push and pop, 0 < count < DEPTH: count unchanged, both pointers advance.
- Pop with empty queue is ignored (rd_valid_o=0, so no pop).
- Flush:
  - flush_i has priority over push and pop in the same cycle.
  - Next state: count=0, rd_ptr=wr_ptr (pointers equal, not zeroed); the same-cycle write is dropped.
  - rd_valid_o=0 from the cycle after flush.
  - Consecutive flush cycles keep the queue empty.
- hold_o:
  - Registered: asserted in cycle N+1 when count in cycle N+1 satisfies (DEPTH - count) <= HOLD_MARGIN.
  - Implemented as a function of next-count, registered.
  - With HOLD_MARGIN=0, hold_o equals full.
- No combinational path from rd_ready_i to wr_ready_o, or from wr_valid_i to rd_valid_o (default build).

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count==0, flush_i=0 and wr_valid_i=1, the write data is forwarded combinationally to the read side: rd_valid_o=1, rd_pc_o=wr_pc_i, rd_instr_o=wr_instr_i.
  - If rd_ready_i=1 in that cycle, the entry is consumed and never stored; pointers and count are unchanged.
  - If rd_ready_i=0, the entry is stored normally and count becomes 1.
  - Zero-cycle latency when empty.
- Not defined: no bypass; 1-cycle latency as in Behaviour.

Test Plan:
- Reset, then write pc=0x10 instr=0xA5A5 with rd_ready_i=0 -> next cycle rd_valid_o=1, rd_pc_o=0x10, rd_instr_o=0xA5A5, count_o=1, hold_o=0.
- DEPTH=4, HOLD_MARGIN=1: write pc 0x00..0x03 back-to-back with no reads:
  - hold_o=1 once count=3.
  - wr_ready_o=0 at count=4.
  - A 5th write of pc=0x04 is refused and count_o stays 4.
- Full queue, wr_valid_i=1 and rd_ready_i=1 together -> pop of pc 0x00 only; count_o=3; next head pc=0x01; the write is not accepted that cycle.
- 10 writes and 10 reads with pointer wrap (pc 0x20..0x29, random rd_ready_i stalls) -> read order exactly 0x20..0x29 with no loss or duplication.
- Queue holding 3 entries, flush_i=1 with wr_valid_i=1 (pc=0x40) in the same cycle -> next cycle count_o=0, rd_valid_o=0, pc 0x40 dropped; a subsequent write of pc=0x41 is read out first.
- rst_n pulsed low for half a cycle while count=2 -> rd_valid_o=0 and count_o=0 immediately, without waiting for a clock edge. With FETCH_QUEUE_BYPASS_EN defined: write pc=0x50 into the empty queue with rd_ready_i=1 -> rd_valid_o=1 and rd_pc_o=0x50 in the same cycle; count_o stays 0.
